// File: rtl/regfile_pkg.sv
// regfile_pkg: write-port op encoding shared by the register file and PC/control logic
package regfile_pkg;
    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_INC  = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;
endpackage

// File: rtl/regfile_next.sv
// regfile_next: next value and valid bit of one entry under a write-port op
module regfile_next
    import regfile_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] cur,
    input  logic             cur_valid,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] nxt,
    output logic             nxt_valid
);
    always_comb begin
        nxt = op == OP_LOAD ? in : op == OP_INC ? cur + WIDTH'(1) : op == OP_CLR ? '0 : cur;
        nxt_valid = op == OP_CLR ? 1'b0 : op == OP_NOP ? cur_valid : 1'b1;
    end
endmodule

// File: rtl/regfile.sv
// regfile: DEPTH x WIDTH register file, one load/inc/clear write port, two combinational read ports
module regfile
    import regfile_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 8,
    parameter int BYPASS = 0,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        op,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  in,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]  out_a,
    output logic [WIDTH-1:0]  out_b,
    output logic [DEPTH-1:0]  valid
);
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] cur, nxt, stored_a, stored_b;
    logic             cur_valid, nxt_valid, wr_ok, ra_ok, rb_ok, fwd;
    always_comb begin
        wr_ok     = {1'b0, waddr} < LIMIT;
        ra_ok     = {1'b0, raddr_a} < LIMIT;
        rb_ok     = {1'b0, raddr_b} < LIMIT;
        cur       = wr_ok ? mem[waddr] : '0;
        cur_valid = wr_ok ? valid[waddr] : 1'b0;
        stored_a  = ra_ok ? mem[raddr_a] : '0;
        stored_b  = rb_ok ? mem[raddr_b] : '0;
        fwd       = BYPASS != 0 && !reset && wr_ok && op != OP_NOP;
        out_a     = fwd && raddr_a == waddr ? nxt : stored_a;
        out_b     = fwd && raddr_b == waddr ? nxt : stored_b;
    end
    // the same unit feeds storage and the bypass path so they never disagree
    regfile_next #(.WIDTH(WIDTH)) u_next (
        .op(op),
        .cur(cur),
        .cur_valid(cur_valid),
        .in(in),
        .nxt(nxt),
        .nxt_valid(nxt_valid)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            valid <= '0;
        end else if (wr_ok && op != OP_NOP) begin
            mem[waddr]   <= nxt;
            valid[waddr] <= nxt_valid;
        end
    end
endmodule

// File: doc/regfile.md
# regfile

Parametrised register file, successor to the single 16-bit `register` in the memories/program-counter task. It holds `DEPTH` words of `WIDTH` bits. Each cycle it accepts one write-port operation (load, increment or clear) and serves two independent combinational read ports. It also provides a per-entry valid mask. It sits between the datapath and the program counter as the general-purpose register storage, and replaces ad-hoc banks of `register` instances.

## Interface
Parameters:
- `WIDTH`, 16: data width in bits (≥1).
- `DEPTH`, 8: number of entries (≥2, need not be a power of 2).
- `BYPASS`, 0: 1 = read ports show the value being written this cycle (write-through); 0 = read ports show stored state only.
- `ADDR_W`, `$clog2(DEPTH)`: address width; derived, not overridden.

Ports:
- `clk`  in  1  single clock, all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; clears all entries and valid bits.
- `op`  in  2  write-port operation: 00 NOP, 01 LOAD, 10 INC, 11 CLR.
- `waddr`  in  ADDR_W  target entry for `op`.
- `in`  in  WIDTH  data for LOAD.
- `raddr_a`  in  ADDR_W  read port A address.
- `raddr_b`  in  ADDR_W  read port B address.
- `out_a`  out  WIDTH  entry `raddr_a` (combinational).
- `out_b`  out  WIDTH  entry `raddr_b` (combinational).
- `valid`  out  DEPTH  bit i = 1 when entry i has been written (LOAD/INC) since its last reset/CLR.

## Operation
- Reset (rising edge with `reset`=1): every entry becomes 0 and `valid` becomes 0. Reset takes precedence over any `op`.
- NOP: no state change.
- LOAD: `mem[waddr] <= in`; `valid[waddr] <= 1`.
- INC: `mem[waddr] <= mem[waddr] + 1`, modulo 2^WIDTH. All-ones wraps to 0 with no flag. `valid[waddr] <= 1`.
- CLR: `mem[waddr] <= 0`; `valid[waddr] <= 0`.
- Only entry `waddr` changes. All other entries hold.
- `waddr` ≥ DEPTH: the op is ignored and no state changes.
- Reads: `out_x = mem[raddr_x]`. If `raddr_x` ≥ DEPTH, `out_x` = 0. Both ports may address the same entry.
- BYPASS=1: when `raddr_x == waddr`, `op` ≠ NOP, `waddr` < DEPTH and `reset`=0, `out_x` shows the next value of that entry (`in`, `mem+1` or 0) combinationally. In every other case it shows the stored value.
- No state machine beyond the storage array. Each entry is an independent register with load/inc/clear.

## Timing
- Write latency: 1 cycle. The new value is in storage after the rising edge on which `op` is sampled.
- Read latency: 0 cycles. Outputs are purely combinational from storage, the read addresses and (for BYPASS) the write-port inputs.
- BYPASS=0, same-cycle read of the entry being written: returns the old value. The new value appears after the edge.
- Reset mid-sequence: the edge with `reset`=1 discards that cycle's `op`. From the next cycle all outputs read 0 and `valid` = 0. While `reset`=1, BYPASS forwarding is suppressed.
- Back-to-back INC on one entry: increments once per cycle (value advances by N after N edges).
- Output values after reset: `out_a` = `out_b` = 0 and `valid` = 0.

## Structure
- Shared package `regfile_pkg` holds the op encoding constants (`OP_NOP`, `OP_LOAD`, `OP_INC`, `OP_CLR`). The PC/control logic imports the same encoding.
- Sub-module `regfile_next`: combinational next-value unit (`op`, current value, `in` → next value, next valid). It is instantiated once for the write port and reused as the bypass source, so the forwarded value and the stored value cannot diverge.
- Storage is a `DEPTH`×`WIDTH` array plus a `DEPTH`-bit valid vector, both in the top module.

## Test plan
DEPTH=8, WIDTH=16 unless noted.
- Reset: load random data into all 8 entries, then assert `reset` 1 cycle → all reads return 0 and `valid`=8'h00, including an edge where `reset`=1 and `op`=LOAD.
- LOAD/read: LOAD 16'hBEEF to entry 3, then read `raddr_a`=3, `raddr_b`=2 → `out_a`=16'hBEEF, `out_b`=0, `valid`=8'h08. With BYPASS=0, the same-cycle read returns 0.
- INC wrap: LOAD 16'hFFFE to entry 5, then INC, INC → 16'hFFFF, then 16'h0000. `valid[5]` stays 1.
- CLR: after the above, CLR entry 5 → reads 0 and `valid[5]`=0. Entry 3 is still 16'hBEEF.
- BYPASS=1: LOAD 16'h1234 to entry 1 with `raddr_a`=1 in the same cycle → `out_a`=16'h1234 before the edge. INC with `raddr_b`=1 → `out_b`=16'h1235 before the edge.
- DEPTH=6: LOAD to `waddr`=7 → no entry changes and `valid` is unchanged. Read `raddr_a`=6 → 0.
